// File: rtl/circle_job_sched_if.sv
// Signal bundle between the circle job scheduler and its surroundings:
// two job requesters, the shared circle engine and the framebuffer port.
interface circle_job_sched_if;
  logic       req0, req1;
  logic [7:0] xc0, xc1;
  logic [6:0] yc0, yc1;
  logic [5:0] r0, r1;
  logic [2:0] col0, col1;
  logic       ack0, ack1;
  logic       done0, done1;
  logic       ovf;
  logic       busy;
  logic [7:0] eng_xc;
  logic [6:0] eng_yc;
  logic [5:0] eng_r;
  logic       eng_plot;
  logic [7:0] eng_xo;
  logic [6:0] eng_yo;
  logic       eng_done;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_col;
  logic       pix_we;

  // Scheduler side
  modport slave (
    input  req0, req1, xc0, xc1, yc0, yc1, r0, r1, col0, col1,
    input  eng_xo, eng_yo, eng_done,
    output ack0, ack1, done0, done1, ovf, busy,
    output eng_xc, eng_yc, eng_r, eng_plot,
    output pix_x, pix_y, pix_col, pix_we
  );

  // Requesters, engine and framebuffer side
  modport master (
    output req0, req1, xc0, xc1, yc0, yc1, r0, r1, col0, col1,
    output eng_xo, eng_yo, eng_done,
    input  ack0, ack1, done0, done1, ovf, busy,
    input  eng_xc, eng_yc, eng_r, eng_plot,
    input  pix_x, pix_y, pix_col, pix_we
  );
endinterface

// File: rtl/circle_job_sched.sv
// Round-robin scheduler feeding draw jobs from two requesters into one
// Bresenham circle engine, with clipped pixel write strobe generation.
module circle_job_sched #(
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120,
  parameter int DRAIN_CYC = 10,
  parameter int RST_HOLD  = 1023
) (
  input  logic             CLK50,
  input  logic             resetn,
  circle_job_sched_if.slave bus
);

  localparam int CNT_MAX = (RST_HOLD > DRAIN_CYC) ? RST_HOLD : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYC - 1);
  localparam logic [8:0]       SCR_W9    = 9'(SCR_W);
  localparam logic [8:0]       SCR_H9    = 9'(SCR_H);

  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_LAUNCH, S_DRAW, S_DRAIN} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0]       r_xc;
  logic [6:0]       r_yc;
  logic [5:0]       r_r;
  logic [2:0]       r_col;
  logic             r_owner, r_last_grant, r_fit;
  logic             w_any_req, w_grant, w_sel, w_fit;
  logic             w_launch, w_finish, w_drawing;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_grant   = (r_state == S_IDLE) & w_any_req;
  // Both requesting: favour the one not served last; otherwise the lone one.
  assign w_sel     = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

  // Whole circle on screen; 9-bit sums so xc+r never wraps.
  assign w_fit = (r_xc >= {2'b00, r_r}) &
                 (({1'b0, r_xc} + {3'b000, r_r}) < SCR_W9) &
                 (r_yc >= {1'b0, r_r}) &
                 (({2'b00, r_yc} + {3'b000, r_r}) < SCR_H9);

  // State and shared counter register
  always_ff @(posedge CLK50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: post-reset hold, arbitration, launch, draw, drain countdown
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == HOLD_END) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_IDLE:   if (w_any_req) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_DRAW;
      S_DRAW: begin
        if (bus.eng_done) begin
          w_next     = S_DRAIN;
          w_cnt_next = '0;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_END) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next     = S_WAIT;
        w_cnt_next = '0;
      end
    endcase
  end

  // Latch the granted job, remember its owner, and capture fit at launch
  always_ff @(posedge CLK50 or negedge resetn) begin
    if (!resetn) begin
      r_xc         <= '0;
      r_yc         <= '0;
      r_r          <= '0;
      r_col        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_fit        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_xc         <= w_sel ? bus.xc1  : bus.xc0;
        r_yc         <= w_sel ? bus.yc1  : bus.yc0;
        r_r          <= w_sel ? bus.r1   : bus.r0;
        r_col        <= w_sel ? bus.col1 : bus.col0;
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
      end
      if (r_state == S_LAUNCH) r_fit <= w_fit;
    end
  end

  assign w_launch  = (r_state == S_LAUNCH);
  assign w_finish  = (r_state == S_DRAIN) & (r_cnt == DRAIN_END);
  assign w_drawing = (r_state == S_DRAW) | (r_state == S_DRAIN);

  assign bus.ack0     = w_launch & ~r_owner;
  assign bus.ack1     = w_launch &  r_owner;
  assign bus.done0    = w_finish & ~r_owner;
  assign bus.done1    = w_finish &  r_owner;
  assign bus.ovf      = w_finish & ~r_fit;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.eng_plot = w_launch;
  assign bus.eng_xc   = r_xc;
  assign bus.eng_yc   = r_yc;
  assign bus.eng_r    = r_r;

  // Pixel stream passes straight through; off-screen coordinates are dropped.
  assign bus.pix_x   = bus.eng_xo;
  assign bus.pix_y   = bus.eng_yo;
  assign bus.pix_col = r_col;
  assign bus.pix_we  = w_drawing &
                       ({1'b0, bus.eng_xo} < SCR_W9) &
                       ({2'b00, bus.eng_yo} < SCR_H9);

endmodule
